axi_ram_slave: RTL and testbench
================================

// Module: axi_ram_slave
// PURPOSE
//  AXI3-style (4-bit LEN, WID present) 32-bit slave backed by a word-addressed internal RAM.
//  Responder counterpart to the core's AXI master port (icache/dcache/uncache traffic via axi_ctrl).
//  Used as simulation and FPGA bring-up memory.
//  Serves one burst at a time, either a read or a write; no interleaving or outstanding queue.
// PARAMETERS
//  MEM_AW    12          word-address width; RAM holds 2**MEM_AW 32-bit words
//  BASE_ADDR 32'h0000_0000  byte base; the window is [BASE_ADDR, BASE_ADDR + 4*2**MEM_AW)
//  RD_LAT    1           idle cycles between AR acceptance and the first rvalid (0..7)
// PORTS
//  aclk     in   1   clock; all logic on its rising edge
//  aresetn  in   1   asynchronous active-low reset
//  arid/araddr/arlen/arsize/arburst  in  4/32/4/3/2   read address channel
//  arlock/arcache/arprot             in  2/4/3        ignored
//  arvalid  in   1   AR handshake
//  arready  out  1   AR handshake
//  rid/rdata/rresp/rlast/rvalid      out 4/32/2/1/1   read data channel
//  rready   in   1   R handshake
//  awid/awaddr/awlen/awsize/awburst  in  4/32/4/3/2   write address channel
//  awlock/awcache/awprot             in  2/4/3        ignored
//  awvalid  in   1   AW handshake
//  awready  out  1   AW handshake
//  wid/wdata/wstrb/wlast/wvalid      in  4/32/4/1/1   write data channel
//  wready   out  1   W handshake
//  bid/bresp/bvalid                  out 4/2/1        write response channel
//  bready   in   1   B handshake
// BEHAVIOUR
//  Reset values: all valid/ready outputs 0; rid/bid/rresp/bresp/rdata/rlast 0; FSM in IDLE.
//  Reset is asynchronous: abandons any burst mid-flight. RAM contents are not cleared.
//  FSM states: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.
//  IDLE: arready = awready = 1 only in IDLE.
//   - Both valid in the same cycle: grant alternates, starting with write after reset;
//     the ungranted channel's ready drops in that cycle.
//   - AR accepted -> RD_WAIT (or RD_DATA if RD_LAT = 0).
//   - AW accepted -> WR_DATA.
//   - Latch id, addr, len, burst; the beat counter counts 0..len, i.e. len+1 beats.
//  Address: word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
//   - INCR (2'b01) and WRAP (2'b10): +4 per beat (WRAP treated as INCR).
//   - FIXED (2'b00): address constant.
//  Out-of-window beat:
//   - read: rdata = 0, rresp = 2'b11 (DECERR);
//   - write: beat dropped, sticky error flag set.
//  Otherwise rresp = 2'b00.
//  arsize/awsize != 3'b010: response SLVERR (2'b10) for every beat; no RAM write.
//  RD_WAIT: counts RD_LAT cycles, then enters RD_DATA.
//  RD_DATA:
//   - rvalid = 1; rdata, rresp, rlast stable while rvalid && !rready.
//   - rlast = 1 on beat len.
//   - The RAM read for the next beat is issued on the rvalid && rready handshake, so
//     back-to-back beats run at 1 beat/cycle with RD_LAT = 0.
//   - Last handshake -> IDLE.
//  WR_DATA:
//   - wready = 1; each wvalid && wready writes the bytes enabled by wstrb[i] (byte i = bits 8i+7:8i).
//   - wlast is ignored; the beat counter terminates the burst. wid is not checked.
//   - After beat len -> WR_RESP.
//  WR_RESP:
//   - bvalid = 1, bid = latched awid.
//   - bresp = 2'b11 if any beat fell out of window, else 2'b10 on a size error, else 2'b00.
//   - bvalid && bready -> IDLE; the error flag clears.
//  Read-after-write to the same address in consecutive bursts returns the new data.
// CONFIGURATION
//  AXI_RAM_STALL_EN defined: a 16-bit LFSR (seed 16'hACE1 at reset, x^16+x^14+x^13+x^11+1)
//   gates arready, awready and wready low, and delays rvalid/bvalid assertion, whenever
//   lfsr[0] = 1. Handshake rules are unchanged; data is never altered.
//  AXI_RAM_STALL_EN undefined: no stall logic; timing exactly as above.
// TESTING
//  1. INCR read, arlen = 15, RD_LAT = 0, rready = 1 held, RAM preloaded with word i = i:
//     16 beats on consecutive cycles, data 0..15, rlast only on beat 15.
//  2. INCR write, awlen = 3, addr 0x40, wstrb 4'b0101, data 32'hFFFFFFFF over old 0:
//     words 0x40..0x4C read back as 32'h00FF00FF; bresp = 0; bid = awid.
//  3. arvalid and awvalid in the same cycle right after reset: write granted first;
//     the next simultaneous pair grants the read.
//  4. Read at BASE_ADDR + 4*2**MEM_AW - 4, arlen = 1: beat 0 OKAY, beat 1 rresp = 2'b11, rdata = 0.
//  5. rready held low for 5 cycles mid-burst: rdata/rlast/rresp remain stable; no beat lost.
//  6. aresetn pulled low mid write burst: all valids and readies are 0 immediately;
//     after release a fresh read returns correct data.

Source files
------------

// File: rtl/axi_ram_slave.sv
// AXI3 32-bit slave over a word-addressed RAM; serves one read or write burst at a time.
// Define AXI_RAM_STALL_EN to add LFSR-driven handshake stalls.
module axi_ram_slave #(
    parameter int          MEM_AW    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          RD_LAT    = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

    state_t state_q, state_d;

    logic [31:0] mem [2**MEM_AW];
    logic [31:0] addr_q;
    logic [31:0] next_addr;
    logic [3:0]  id_q;
    logic [3:0]  len_q;
    logic [3:0]  cnt_q;
    logic [1:0]  burst_q;
    logic [2:0]  lat_q;
    logic        size_err_q;
    logic        oow_err_q;
    logic        grant_wr_q;
    logic        out_en_q;
    logic        ar_hs, aw_hs, r_hs, w_hs, b_hs;
    logic        last_beat;
    logic        stall;
    logic        rv_gate;
    logic        bv_gate;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic        ld_serr;
    logic        ld_last;
    logic        unused_ok;

    assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache,
                         awprot, wid, wlast};

    function automatic logic in_win(input logic [31:0] a);
        return ((a - BASE_ADDR) >> (MEM_AW + 2)) == 32'd0;
    endfunction

    function automatic logic [MEM_AW-1:0] widx(input logic [31:0] a);
        return MEM_AW'((a - BASE_ADDR) >> 2);
    endfunction

`ifdef AXI_RAM_STALL_EN
    logic [15:0] lfsr_q;
    logic        rv_hold_q;
    logic        bv_hold_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lfsr_q    <= 16'hACE1;
            rv_hold_q <= 1'b0;
            bv_hold_q <= 1'b0;
        end else begin
            lfsr_q    <= {lfsr_q[14:0],
                          lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            rv_hold_q <= rvalid & ~rready;
            bv_hold_q <= bvalid & ~bready;
        end
    end

    // once raised, a valid must stay up until its handshake
    assign stall   = lfsr_q[0];
    assign rv_gate = rv_hold_q | ~stall;
    assign bv_gate = bv_hold_q | ~stall;
`else
    assign stall   = 1'b0;
    assign rv_gate = 1'b1;
    assign bv_gate = 1'b1;
`endif

    assign ar_hs     = arvalid & arready;
    assign aw_hs     = awvalid & awready;
    assign r_hs      = rvalid & rready;
    assign w_hs      = wvalid & wready;
    assign b_hs      = bvalid & bready;
    assign last_beat = (cnt_q == len_q);
    assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + 32'd4;
    assign rid       = id_q;
    assign bid       = id_q;

    always_comb begin
        state_d = state_q;
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        rvalid  = 1'b0;
        bvalid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (out_en_q && !stall) begin
                    awready = !(arvalid && !grant_wr_q);
                    arready = !(awvalid && grant_wr_q);
                end
                if (awvalid && awready)
                    state_d = WR_DATA;
                else if (arvalid && arready)
                    state_d = (RD_LAT == 0) ? RD_DATA : RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_q == 3'(RD_LAT - 1))
                    state_d = RD_DATA;
            end
            RD_DATA: begin
                rvalid = rv_gate;
                if (rvalid && rready && last_beat)
                    state_d = IDLE;
            end
            WR_DATA: begin
                wready = !stall;
                if (wvalid && wready && last_beat)
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                bvalid = bv_gate;
                if (bvalid && bready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            id_q       <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            burst_q    <= '0;
            lat_q      <= '0;
            size_err_q <= 1'b0;
            oow_err_q  <= 1'b0;
            grant_wr_q <= 1'b1;
            out_en_q   <= 1'b0;
            bresp      <= '0;
        end else begin
            state_q  <= state_d;
            out_en_q <= 1'b1;
            if (ar_hs || aw_hs) begin
                addr_q     <= ar_hs ? araddr : awaddr;
                id_q       <= ar_hs ? arid : awid;
                len_q      <= ar_hs ? arlen : awlen;
                burst_q    <= ar_hs ? arburst : awburst;
                size_err_q <= ar_hs ? (arsize != 3'b010) : (awsize != 3'b010);
                cnt_q      <= '0;
                lat_q      <= '0;
                if (arvalid && awvalid)
                    grant_wr_q <= ~grant_wr_q;
            end
            if (state_q == RD_WAIT)
                lat_q <= lat_q + 3'd1;
            if (r_hs || w_hs) begin
                cnt_q  <= cnt_q + 4'd1;
                addr_q <= next_addr;
            end
            if (w_hs && !in_win(addr_q))
                oow_err_q <= 1'b1;
            if (w_hs && last_beat)
                bresp <= (oow_err_q || !in_win(addr_q)) ? 2'b11 :
                         size_err_q ? 2'b10 : 2'b00;
            if (b_hs)
                oow_err_q <= 1'b0;
        end
    end

    // next read beat is fetched on acceptance or on each handshake
    always_comb begin
        ld_en   = 1'b0;
        ld_addr = araddr;
        ld_serr = (arsize != 3'b010);
        ld_last = (arlen == 4'd0);
        if (ar_hs) begin
            ld_en = 1'b1;
        end else if (r_hs && !last_beat) begin
            ld_en   = 1'b1;
            ld_addr = next_addr;
            ld_serr = size_err_q;
            ld_last = ((cnt_q + 4'd1) == len_q);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdata <= '0;
            rresp <= '0;
            rlast <= 1'b0;
        end else if (ld_en) begin
            if (!in_win(ld_addr)) begin
                rdata <= '0;
                rresp <= 2'b11;
            end else if (ld_serr) begin
                rdata <= '0;
                rresp <= 2'b10;
            end else begin
                rdata <= mem[widx(ld_addr)];
                rresp <= 2'b00;
            end
            rlast <= ld_last;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && in_win(addr_q) && !size_err_q) begin
            for (int i = 0; i < 4; i++)
                if (wstrb[i])
                    mem[widx(addr_q)][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Bench for axi_ram_slave: table vectors, hand sequences and random bursts
// checked against a word-array memory model.
module tb_axi_ram_slave;

    localparam int          AW    = 8;
    localparam int          WORDS = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic        arvalid, arready, awvalid, awready;
    logic        rvalid, rready, rlast;
    logic        wvalid, wready, wlast;
    logic        bvalid, bready;

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    axi_ram_slave #(
        .MEM_AW   (AW),
        .BASE_ADDR(BASE),
        .RD_LAT   (0)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache),
        .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    logic [31:0] model [WORDS];
    logic [31:0] wbuf [16];
    logic [31:0] rq [$];
    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  strb;
        int          dmode;
        logic [1:0]  bresp;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] baddr(input logic [31:0] a,
                                          input logic [1:0] b, input int k);
        return (b == 2'b00) ? a : a + 32'(4 * k);
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        return (a - BASE) < 32'(4 * WORDS);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [1:0] exp_b(input logic [31:0] a,
                                         input logic [3:0] len,
                                         input logic [2:0] sz,
                                         input logic [1:0] b);
        bit oow = 1'b0;
        for (int k = 0; k <= int'(len); k++)
            if (!in_win(baddr(a, b, k))) oow = 1'b1;
        return oow ? 2'b11 : (sz != 3'b010) ? 2'b10 : 2'b00;
    endfunction

    task automatic aw_send(input logic [3:0] id, input logic [31:0] a,
                           input logic [3:0] len, input logic [2:0] sz,
                           input logic [1:0] b);
        bit hs = 1'b0;
        awid = id; awaddr = a; awlen = len; awsize = sz; awburst = b;
        awvalid = 1'b1;
        for (int t = 0; t < 100 && !hs; t++) begin
            @(negedge aclk); hs = awready;
            @(posedge aclk); #1;
        end
        awvalid = 1'b0;
        chk("aw_accept", 32'(hs), 32'd1);
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] a,
                           input logic [3:0] len, input logic [2:0] sz,
                           input logic [1:0] b);
        bit hs = 1'b0;
        arid = id; araddr = a; arlen = len; arsize = sz; arburst = b;
        arvalid = 1'b1;
        for (int t = 0; t < 100 && !hs; t++) begin
            @(negedge aclk); hs = arready;
            @(posedge aclk); #1;
        end
        arvalid = 1'b0;
        chk("ar_accept", 32'(hs), 32'd1);
    endtask

    task automatic w_send(input logic [3:0] id, input logic [31:0] a,
                          input logic [3:0] len, input logic [2:0] sz,
                          input logic [1:0] b, input logic [3:0] strb,
                          input int nb, input bit gaps);
        logic [31:0] ad;
        bit hs;
        for (int k = 0; k < nb; k++) begin
            if (gaps)
                repeat ($urandom_range(0, 2)) begin
                    @(posedge aclk); #1;
                end
            hs = 1'b0;
            wid = id; wdata = wbuf[k]; wstrb = strb;
            wlast = (k == int'(len)); wvalid = 1'b1;
            for (int t = 0; t < 100 && !hs; t++) begin
                @(negedge aclk); hs = wready;
                @(posedge aclk); #1;
            end
            wvalid = 1'b0;
            chk("w_accept", 32'(hs), 32'd1);
            ad = baddr(a, b, k);
            if (hs && in_win(ad) && sz == 3'b010)
                for (int i = 0; i < 4; i++)
                    if (strb[i]) model[widx(ad)][8*i +: 8] = wbuf[k][8*i +: 8];
        end
    endtask

    task automatic b_recv(input logic [3:0] id, input logic [1:0] exp);
        bit seen = 1'b0;
        logic [1:0] r = 2'bxx;
        logic [3:0] i = 4'bxxxx;
        bready = 1'b1;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge aclk);
            if (bvalid) begin
                seen = 1'b1; r = bresp; i = bid;
            end
            @(posedge aclk); #1;
        end
        bready = 1'b0;
        chk("b_seen", 32'(seen), 32'd1);
        chk("bresp", 32'(r), 32'(exp));
        chk("bid", 32'(i), 32'(id));
    endtask

    // mode 0: rready held high, beats must be back to back
    // mode 1: random rready; mode 2: rready low 5 cycles after beat 1
    task automatic r_recv(input logic [3:0] id, input logic [31:0] a,
                          input logic [3:0] len, input logic [2:0] sz,
                          input logic [1:0] b, input int mode);
        int k = 0, hold = 0, last_cyc = 0;
        logic [31:0] ad, ed, sd;
        logic [1:0]  er, sr;
        logic        sl;
        rq.delete();
        rready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int t = 0; t < 300 && k <= int'(len); t++) begin
            @(negedge aclk);
            if (rvalid && rready) begin
                ad = baddr(a, b, k);
                if (!in_win(ad)) begin
                    ed = 32'd0; er = 2'b11;
                end else if (sz != 3'b010) begin
                    ed = 32'd0; er = 2'b10;
                end else begin
                    ed = model[widx(ad)]; er = 2'b00;
                end
                chk("rresp", 32'(rresp), 32'(er));
                if (er != 2'b10) chk("rdata", rdata, ed);
                chk("rlast", 32'(rlast), 32'(k == int'(len)));
                chk("rid", 32'(rid), 32'(id));
                if (mode == 0 && k > 0)
                    chk("r_gap", 32'(cyc - last_cyc), 32'd1);
                last_cyc = cyc;
                rq.push_back(rdata);
                k++;
                if (mode == 2 && k == 2) hold = 5;
            end else if (hold > 0) begin
                if (hold == 5) begin
                    sd = rdata; sr = rresp; sl = rlast;
                    chk("r_hold_valid", 32'(rvalid), 32'd1);
                end else begin
                    chk("r_hold_data", rdata, sd);
                    chk("r_hold_resp", 32'(rresp), 32'(sr));
                    chk("r_hold_last", 32'(rlast), 32'(sl));
                end
                hold--;
            end
            @(posedge aclk); #1;
            if (hold > 0) rready = 1'b0;
            else if (mode == 1) rready = 1'($urandom_range(0, 1));
            else rready = 1'b1;
        end
        rready = 1'b0;
        chk("r_beats", 32'(k), 32'(int'(len) + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  rid_v, rlen;
        logic [31:0] ra;
        logic [2:0]  rsz;
        logic [1:0]  rb;
        logic [3:0]  rst;

        tbl[0] = '{4'h1, 32'h040, 4'd3, 3'b010, 2'b01, 4'hF, 0, 2'b00};
        tbl[1] = '{4'h3, 32'h040, 4'd3, 3'b010, 2'b01, 4'h5, 1, 2'b00};
        tbl[2] = '{4'h7, 32'h3F8, 4'd3, 3'b010, 2'b01, 4'hF, 2, 2'b11};
        tbl[3] = '{4'h9, 32'h100, 4'd2, 3'b010, 2'b00, 4'hF, 2, 2'b00};
        tbl[4] = '{4'hA, 32'h200, 4'd1, 3'b001, 2'b01, 4'hF, 2, 2'b10};
        tbl[5] = '{4'hF, 32'h080, 4'd3, 3'b010, 2'b10, 4'h8, 2, 2'b00};
        tbl[6] = '{4'h2, 32'h400, 4'd0, 3'b011, 2'b01, 4'hF, 2, 2'b11};
        tbl[7] = '{4'h4, 32'h3FC, 4'd1, 3'b010, 2'b01, 4'hF, 2, 2'b11};
        tbl[8] = '{4'h5, 32'h0C3, 4'd1, 3'b010, 2'b01, 4'hF, 2, 2'b00};

        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_hs", 32'({arready, awready, wready, rvalid, bvalid}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_misc", 32'({rid, bid, rresp, bresp, rlast}), 32'd0);
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;

        // simultaneous AR/AW: write first, then read
        wbuf[0] = $urandom;
        awid = 4'h6; awaddr = 32'h20; awlen = 4'd0; awsize = 3'b010;
        awburst = 2'b01; awvalid = 1'b1;
        arid = 4'h9; araddr = 32'h20; arlen = 4'd0; arsize = 3'b010;
        arburst = 2'b01; arvalid = 1'b1;
        @(negedge aclk);
        chk("grant1_aw", 32'(awready), 32'd1);
        chk("grant1_ar", 32'(arready), 32'd0);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        w_send(4'h6, 32'h20, 4'd0, 3'b010, 2'b01, 4'hF, 1, 1'b0);
        b_recv(4'h6, 2'b00);
        ar_send(4'h9, 32'h20, 4'd0, 3'b010, 2'b01);
        r_recv(4'h9, 32'h20, 4'd0, 3'b010, 2'b01, 0);

        wbuf[0] = $urandom;
        awid = 4'h2; awaddr = 32'h24; awlen = 4'd0; awsize = 3'b010;
        awburst = 2'b01; awvalid = 1'b1;
        arid = 4'h3; araddr = 32'h20; arlen = 4'd0; arsize = 3'b010;
        arburst = 2'b01; arvalid = 1'b1;
        @(negedge aclk);
        chk("grant2_ar", 32'(arready), 32'd1);
        chk("grant2_aw", 32'(awready), 32'd0);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        r_recv(4'h3, 32'h20, 4'd0, 3'b010, 2'b01, 0);
        aw_send(4'h2, 32'h24, 4'd0, 3'b010, 2'b01);
        w_send(4'h2, 32'h24, 4'd0, 3'b010, 2'b01, 4'hF, 1, 1'b0);
        b_recv(4'h2, 2'b00);

        // preload word i = i
        for (int bi = 0; bi < 16; bi++) begin
            for (int k = 0; k < 16; k++) wbuf[k] = 32'(bi * 16 + k);
            aw_send(4'(bi), 32'(bi * 64), 4'd15, 3'b010, 2'b01);
            w_send(4'(bi), 32'(bi * 64), 4'd15, 3'b010, 2'b01, 4'hF, 16, 1'b0);
            b_recv(4'(bi), 2'b00);
        end

        ar_send(4'h1, 32'h0, 4'd15, 3'b010, 2'b01);
        r_recv(4'h1, 32'h0, 4'd15, 3'b010, 2'b01, 0);
        foreach (rq[k]) chk("t1_data", rq[k], 32'(k));

        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < 16; k++)
                wbuf[k] = (tbl[i].dmode == 0) ? 32'h0 :
                          (tbl[i].dmode == 1) ? 32'hFFFF_FFFF : $urandom;
            aw_send(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst);
            w_send(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst,
                   tbl[i].strb, int'(tbl[i].len) + 1, 1'b0);
            b_recv(tbl[i].id, tbl[i].bresp);
            ar_send(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst);
            r_recv(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, 0);
            if (i == 1)
                foreach (rq[k]) chk("t2_data", rq[k], 32'h00FF_00FF);
        end

        ar_send(4'hC, 32'h0, 4'd7, 3'b010, 2'b01);
        r_recv(4'hC, 32'h0, 4'd7, 3'b010, 2'b01, 2);

        for (int it = 0; it < 24; it++) begin
            rid_v = 4'($urandom);
            ra    = 32'($urandom_range(0, 32'h43F));
            rlen  = 4'($urandom);
            rsz   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b010;
            rb    = 2'($urandom_range(0, 2));
            rst   = 4'($urandom);
            for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
            aw_send(rid_v, ra, rlen, rsz, rb);
            w_send(rid_v, ra, rlen, rsz, rb, rst, int'(rlen) + 1, 1'b1);
            b_recv(rid_v, exp_b(ra, rlen, rsz, rb));
            ar_send(rid_v, ra, rlen, rsz, rb);
            r_recv(rid_v, ra, rlen, rsz, rb, 1);
        end

        // reset in the middle of a write burst
        for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
        aw_send(4'hE, 32'h300, 4'd7, 3'b010, 2'b01);
        w_send(4'hE, 32'h300, 4'd7, 3'b010, 2'b01, 4'hF, 3, 1'b0);
        aresetn = 1'b0;
        #1;
        chk("rst_mid_hs", 32'({arready, awready, wready, rvalid, bvalid}), 32'd0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        ar_send(4'h8, 32'h0, 4'd3, 3'b010, 2'b01);
        r_recv(4'h8, 32'h0, 4'd3, 3'b010, 2'b01, 0);
        ar_send(4'hB, 32'h300, 4'd2, 3'b010, 2'b01);
        r_recv(4'hB, 32'h300, 4'd2, 3'b010, 2'b01, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
